// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, RGB444 layout and colour-bar palette.
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int CNT_W  = 10;
  localparam int ADDR_W = 19;
  localparam int CH_W   = 4;
  localparam int RGB_W  = 3 * CH_W;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb444_t;

  // Stage-0 control bits travelling down the pixel pipeline; syncs are active-low.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic fs;
  } sync_t;

  localparam rgb444_t BAR_WHITE   = 12'hFFF;
  localparam rgb444_t BAR_YELLOW  = 12'hFF0;
  localparam rgb444_t BAR_CYAN    = 12'h0FF;
  localparam rgb444_t BAR_GREEN   = 12'h0F0;
  localparam rgb444_t BAR_MAGENTA = 12'hF0F;
  localparam rgb444_t BAR_RED     = 12'hF00;
  localparam rgb444_t BAR_BLUE    = 12'h00F;
  localparam rgb444_t BAR_BLACK   = 12'h000;

  function automatic rgb444_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = BAR_WHITE;
      3'd1:    bar_colour = BAR_YELLOW;
      3'd2:    bar_colour = BAR_CYAN;
      3'd3:    bar_colour = BAR_GREEN;
      3'd4:    bar_colour = BAR_MAGENTA;
      3'd5:    bar_colour = BAR_RED;
      3'd6:    bar_colour = BAR_BLUE;
      default: bar_colour = BAR_BLACK;
    endcase
  endfunction
endpackage

// File: rtl/vga_scanout_if.sv
// VRAM read port (port B) as seen from the scanout side.
interface vga_scanout_if;
  import vga_pkg::*;
  logic [ADDR_W-1:0] vram_addr;
  logic [RGB_W-1:0]  vram_dout;

  modport master (output vram_addr, input vram_dout);
  modport slave  (input vram_addr, output vram_dout);
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical counters and stage-0 active, sync and frame-start decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcnt_o,
  output sync_t            s0_o,
  output logic             frame_end_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic             h_last, v_last;

  always_comb begin
    h_last = (hcnt_q == H_LAST);
    v_last = (vcnt_q == V_LAST);
    hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_comb begin
    s0_o.active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    s0_o.hs     = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    s0_o.vs     = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    s0_o.fs     = (hcnt_q == '0) && (vcnt_q == '0);
  end

  assign hcnt_o      = hcnt_q;
  assign frame_end_o = h_last && v_last;
endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: linear VRAM address generation plus 2-stage pixel/sync pipeline to the pins.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic            clk,
  input  logic            rst,
  vga_scanout_if.master   vram,
  input  logic            test_mode,
  output logic [CH_W-1:0] vga_r,
  output logic [CH_W-1:0] vga_g,
  output logic [CH_W-1:0] vga_b,
  output logic            vga_hs,
  output logic            vga_vs,
  output logic            frame_start
);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam sync_t SYNC_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  sync_t             s0, s1_q;
  logic              frame_end;
  logic [CNT_W-1:0]  hcnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  rgb444_t           rgb_q, rgb_d;
  logic              hs_q, vs_q, fs_q;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .hcnt_o     (hcnt),
    .s0_o       (s0),
    .frame_end_o(frame_end)
  );

  // Parks on the last pixel after the final active cycle so the bus never leaves the frame.
  always_comb begin
    addr_d = addr_q;
    if (frame_end) addr_d = '0;
    else if (s0.active && (addr_q != ADDR_MAX)) addr_d = addr_q + 1'b1;
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
  logic [2:0] bar0, bar1_q;
  logic       tm1_q;

  assign bar0 = 3'(hcnt / BAR_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      bar1_q <= '0;
      tm1_q  <= 1'b0;
    end else begin
      bar1_q <= bar0;
      tm1_q  <= test_mode;
    end
  end

  always_comb begin
    rgb_d = '0;
    if (s1_q.active) rgb_d = tm1_q ? bar_colour(bar1_q) : rgb444_t'(vram.vram_dout);
  end
`else
  logic             unused_test_mode;
  logic [CNT_W-1:0] unused_hcnt;
  assign unused_test_mode = test_mode;
  assign unused_hcnt      = hcnt;

  always_comb begin
    rgb_d = '0;
    if (s1_q.active) rgb_d = rgb444_t'(vram.vram_dout);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      s1_q   <= SYNC_IDLE;
      rgb_q  <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      s1_q   <= s0;
      rgb_q  <= rgb_d;
      hs_q   <= s1_q.hs;
      vs_q   <= s1_q.vs;
      fs_q   <= s1_q.fs;
    end
  end

  assign vram.vram_addr = addr_q;
  assign vga_r          = rgb_q.r;
  assign vga_g          = rgb_q.g;
  assign vga_b          = rgb_q.b;
  assign vga_hs         = hs_q;
  assign vga_vs         = vs_q;
  assign frame_start    = fs_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster so several frames fit in a short run.
module tb_vga_scanout;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NPIX  = HA * VA;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;
  localparam exp_t RST_E = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       test_mode = 1'b0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, frame_start;

  vga_scanout_if vram();

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vram       (vram),
    .test_mode  (test_mode),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  logic [11:0] mem [NPIX];
  always @(posedge clk)
    vram.vram_dout <= (int'(vram.vram_addr) < NPIX) ? mem[int'(vram.vram_addr)] : 12'h000;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] bar_ref(input int idx);
    case (idx)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic exp_t expect_at(input int h, input int v, input logic tm);
    exp_t e;
    logic act;
    act   = (h < HA) && (v < VA);
    e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    e.fs  = (h == 0) && (v == 0);
    e.rgb = act ? mem[v * HA + h] : 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    if (act && tm) e.rgb = bar_ref(h / (HA / 8));
`else
    if (tm) e.rgb = e.rgb;
`endif
    return e;
  endfunction

  // Model raster position of the DUT counters during the current cycle.
  int   mh = 0, mv = 0;
  exp_t sb[$];
  exp_t cur = RST_E;

  initial begin
    int   hs_per = 0, hs_lo = 0, fs_gap = 0, vs_low = 0;
    logic hs_prev = 1'b1, hs_fall_ok = 1'b0, hs_lo_ok = 1'b0, fs_ok = 1'b0;
    forever begin
      @(negedge clk);
      check("rgb", {vga_r, vga_g, vga_b}, cur.rgb);
      check("hs", vga_hs, cur.hs);
      check("vs", vga_vs, cur.vs);
      check("frame_start", frame_start, cur.fs);
      if (mh < HA && mv < VA) check("addr", vram.vram_addr, mv * HA + mh);
      else check("addr_in_range", int'(vram.vram_addr) <= NPIX - 1, 1);
      if (mh == HT - 1 && mv == VT - 1) check("addr_hold_last", vram.vram_addr, NPIX - 1);

      if (!vga_hs) begin
        if (hs_prev) begin
          if (hs_fall_ok) check("hs_period", hs_per, HT);
          hs_fall_ok = 1'b1; hs_per = 0; hs_lo = 0; hs_lo_ok = 1'b1;
        end
        hs_lo++;
      end else if (!hs_prev && hs_lo_ok) begin
        check("hs_low_width", hs_lo, HS);
      end
      hs_per++;
      hs_prev = vga_hs;

      if (frame_start) begin
        if (fs_ok) begin
          check("frame_period", fs_gap, FRAME);
          check("vs_low_width", vs_low, VS * HT);
        end
        fs_ok = 1'b1; fs_gap = 0; vs_low = 0;
      end
      fs_gap++;
      if (!vga_vs) vs_low++;

      if (rst) begin
        sb.delete();
        sb.push_back(RST_E);
        cur = RST_E;
        mh = 0; mv = 0;
        hs_fall_ok = 1'b0; hs_lo_ok = 1'b0; fs_ok = 1'b0;
      end else begin
        sb.push_back(expect_at(mh, mv, test_mode));
        cur = sb.pop_front();
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
  endtask

  initial begin
    logic hit;
    for (int i = 0; i < NPIX; i++) mem[i] = 12'(i * 97 + 3) ^ 12'hA5A;
    cycles(3);
    rst = 1'b0;
    cycles(2 * FRAME + 10);

    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      if (mh == HA / 2 && mv == VA / 2) hit = 1'b1;
      else cycles(1);
    end
    check("mid_reset_reached", hit, 1'b1);
    do_reset(3);
    cycles(FRAME + FRAME / 2);

    rst = 1'b1;
    for (int i = 0; i < NPIX; i++) mem[i] = 12'hFFF;
    cycles(2);
    rst = 1'b0;
    cycles(2 * FRAME + 5);

    rst = 1'b1;
    for (int i = 0; i < NPIX; i++) mem[i] = 12'(i * 13 + 1);
    test_mode = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(FRAME + 20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
